// File: rtl/traffic_pkg.sv
// Shared phase encoding and head colour constants for intersection_scheduler.
// Head outputs are active-low: a 0 bit lights that lamp. Head vectors are {red,green,blue}.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    A_GREEN   = 3'd1,
    A_CAUTION = 3'd2,
    ALL_RED_B = 3'd3,
    B_GREEN   = 3'd4,
    B_CAUTION = 3'd5,
    WALK      = 3'd6,
    BAD_PHASE = 3'd7
  } phase_e;

  localparam logic [2:0] HEAD_RED     = 3'b011;
  localparam logic [2:0] HEAD_GREEN   = 3'b101;
  localparam logic [2:0] HEAD_CAUTION = 3'b110;

  // Each head is red everywhere except its own green and caution phases.
  function automatic logic [2:0] head_of(phase_e p, phase_e grn, phase_e cau);
    logic [2:0] h;
    if (p == grn) begin
      h = HEAD_GREEN;
    end else if (p == cau) begin
      h = HEAD_CAUTION;
    end else begin
      h = HEAD_RED;
    end
    return h;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Phase dwell counter: counts up from zero after a clear and flags done at the
// programmed last count; it holds there rather than wrapping.
module phase_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  assign done = (cnt_q == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (!done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase FSM with optional pedestrian walk phase,
// enabled by defining TRAFFIC_PED_EN. All outputs are registered.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int RED_CLR_CYC = 12_000_000,
  parameter int GREEN_CYC   = 120_000_000,
  parameter int CAUTION_CYC = 48_000_000,
  parameter int WALK_CYC    = 240_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       a_red,
  output logic       a_green,
  output logic       a_blue,
  output logic       b_red,
  output logic       b_green,
  output logic       b_blue,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_CLR_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] CAU_LAST   = CNT_W'(CAUTION_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYC - 1);

  phase_e           state_q, state_d;
  logic [2:0]       a_head_q, b_head_q;
  logic             walk_q, walk_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] last_s;
  logic             done_s;
  logic             clr_s;

`ifdef TRAFFIC_PED_EN
  logic pending_q, pending_d;
`else
  logic ped_unused_s;
  assign ped_unused_s = ped_req;
`endif

  assign clr_s = (state_d != state_q);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .last (last_s),
    .done (done_s)
  );

  always_comb begin
    last_s = WALK_LAST;
    case (state_q)
      ALL_RED_A, ALL_RED_B: last_s = RED_LAST;
      A_GREEN, B_GREEN:     last_s = GREEN_LAST;
      A_CAUTION, B_CAUTION: last_s = CAU_LAST;
      default:              last_s = WALK_LAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    walk_d  = 1'b0;
    ack_d   = 1'b0;
`ifdef TRAFFIC_PED_EN
    pending_d = pending_q;
`endif
    case (state_q)
      ALL_RED_A: if (done_s) state_d = A_GREEN;   else state_d = state_q;
      A_GREEN:   if (done_s) state_d = A_CAUTION; else state_d = state_q;
      A_CAUTION: if (done_s) state_d = ALL_RED_B; else state_d = state_q;
      ALL_RED_B: if (done_s) state_d = B_GREEN;   else state_d = state_q;
      B_GREEN:   if (done_s) state_d = B_CAUTION; else state_d = state_q;
      B_CAUTION: begin
        if (done_s) begin
`ifdef TRAFFIC_PED_EN
          // A request in the final caution cycle still wins this round.
          if (pending_q || ped_req) state_d = WALK;
          else                      state_d = ALL_RED_A;
`else
          state_d = ALL_RED_A;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef TRAFFIC_PED_EN
      WALK:      if (done_s) state_d = ALL_RED_A; else state_d = state_q;
`endif
      default:   state_d = ALL_RED_A;
    endcase
`ifdef TRAFFIC_PED_EN
    if (state_d == WALK && state_q != WALK) begin
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else if (ped_req && state_q != WALK) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    walk_d = (state_d == WALK);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ALL_RED_A;
      a_head_q <= HEAD_RED;
      b_head_q <= HEAD_RED;
      walk_q   <= 1'b0;
      ack_q    <= 1'b0;
`ifdef TRAFFIC_PED_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_head_q <= head_of(state_d, A_GREEN, A_CAUTION);
      b_head_q <= head_of(state_d, B_GREEN, B_CAUTION);
      walk_q   <= walk_d;
      ack_q    <= ack_d;
`ifdef TRAFFIC_PED_EN
      pending_q <= pending_d;
`endif
    end
  end

  assign {a_red, a_green, a_blue} = a_head_q;
  assign {b_red, b_green, b_blue} = b_head_q;
  assign walk    = walk_q;
  assign ped_ack = ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler; the walk sequences apply when
// TRAFFIC_PED_EN is defined, otherwise ped_req is held high and must be ignored.
module tb_intersection_scheduler;

  localparam int RC = 2;
  localparam int GC = 5;
  localparam int CC = 3;
  localparam int WC = 4;

`ifdef TRAFFIC_PED_EN
  localparam logic PED_HOLD = 1'b0;
`else
  localparam logic PED_HOLD = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ped_req;
  logic       ped_ack;
  logic       a_red, a_green, a_blue;
  logic       b_red, b_green, b_blue;
  logic       walk;
  logic [2:0] phase;

  int n_chk  = 0;
  int n_fail = 0;

  intersection_scheduler #(
    .RED_CLR_CYC (RC),
    .GREEN_CYC   (GC),
    .CAUTION_CYC (CC),
    .WALK_CYC    (WC),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ped_req (ped_req),
    .ped_ack (ped_ack),
    .a_red   (a_red),
    .a_green (a_green),
    .a_blue  (a_blue),
    .b_red   (b_red),
    .b_green (b_green),
    .b_blue  (b_blue),
    .walk    (walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ped;
    logic [2:0] ph;
    logic       wlk;
    logic       ack;
  } vec_t;

  vec_t tbl[51];

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_head(input logic [2:0] ph, input bit is_a);
    logic [2:0] grn, cau;
    grn = is_a ? 3'd1 : 3'd4;
    cau = is_a ? 3'd2 : 3'd5;
    if (ph == grn)      return 3'b101;
    else if (ph == cau) return 3'b110;
    else                return 3'b011;
  endfunction

  // Phase shown pos cycles after the start of a walk-free round.
  function automatic logic [2:0] phase_at(input int pos);
    int dw[6];
    int p;
    dw = '{RC, GC, CC, RC, GC, CC};
    p = pos;
    for (int s = 0; s < 6; s++) begin
      if (p < dw[s]) return 3'(s);
      p -= dw[s];
    end
    return 3'd7;
  endfunction

  task automatic check_all(input logic [2:0] ph, input logic w, input logic ack);
    chk("phase", phase, ph);
    chk("head_a", {a_red, a_green, a_blue}, exp_head(ph, 1'b1));
    chk("head_b", {b_red, b_green, b_blue}, exp_head(ph, 1'b0));
    chk("walk", {2'b00, walk}, {2'b00, w});
    chk("ped_ack", {2'b00, ped_ack}, {2'b00, ack});
    chk("excl", {2'b00, a_red & b_red}, 3'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 none, 1 pulse in first cycle, 2 only in last cycle, 3 every cycle.
  task automatic run_phase(input logic [2:0] ph, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      check_all(ph, ph == 3'd6, (ph == 3'd6) && (i == 0));
      ped_req = (mode == 3) || (mode == 1 && i == 0) || (mode == 2 && i == n - 1);
      step();
    end
    ped_req = 1'b0;
  endtask

  task automatic run_round(input int a_mode, input int last_mode);
    run_phase(3'd0, RC, 0);
    run_phase(3'd1, GC, a_mode);
    run_phase(3'd2, CC, 0);
    run_phase(3'd3, RC, 0);
    run_phase(3'd4, GC, 0);
    run_phase(3'd5, CC, last_mode);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    ped_req = 1'b0;

    idx = 0;
    for (int i = 0; i < 3; i++) begin
      tbl[idx] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
      idx++;
    end
    for (int k = 1; k <= 44; k++) begin
      tbl[idx] = '{1'b0, PED_HOLD, phase_at(k % 20), 1'b0, 1'b0};
      idx++;
    end
    tbl[idx] = '{1'b1, PED_HOLD, 3'd0, 1'b0, 1'b0};
    idx++;
    for (int k = 1; k <= 3; k++) begin
      tbl[idx] = '{1'b0, PED_HOLD, phase_at(k % 20), 1'b0, 1'b0};
      idx++;
    end

    for (int i = 0; i < idx; i++) begin
      rst = tbl[i].rst;
      ped_req = tbl[i].ped;
      step();
      check_all(tbl[i].ph, tbl[i].wlk, tbl[i].ack);
    end

`ifdef TRAFFIC_PED_EN
    // Pulse in A_GREEN: walk after B_CAUTION, then a walk-free round.
    do_reset();
    run_round(1, 0);
    run_phase(3'd6, WC, 0);
    run_round(0, 0);
    check_all(3'd0, 1'b0, 1'b0);

    // Request only in the last B_CAUTION cycle; held through WALK.
    do_reset();
    run_round(0, 2);
    run_phase(3'd6, WC, 3);
    run_round(0, 0);
    check_all(3'd0, 1'b0, 1'b0);

    // Reset in the second WALK cycle discards the walk and any pending request.
    do_reset();
    run_round(1, 0);
    run_phase(3'd6, 1, 0);
    check_all(3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all(3'd0, 1'b0, 1'b0);
    run_round(0, 0);
    check_all(3'd0, 1'b0, 1'b0);
`else
    // Held request must never open a walk; period stays 20.
    do_reset();
    ped_req = 1'b1;
    for (int k = 0; k < 41; k++) begin
      check_all(phase_at(k % 20), 1'b0, 1'b0);
      step();
    end
    ped_req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-approach intersection controller sequencing two three-colour signal heads (approach A, approach B) plus a pedestrian walk phase. It replaces per-head free-running timers with a single phase FSM, so the two vehicle heads can never show non-red simultaneously. It sits between the board clock and the RGB LED pins of both heads, with a debounced pedestrian button as its only request input.

## Interface
- `RED_CLR_CYC`, default 12_000_000: all-red clearance duration in cycles; must be ≥1.
- `GREEN_CYC`, default 120_000_000: green duration per approach; must be ≥1.
- `CAUTION_CYC`, default 48_000_000: caution (blue) duration per approach; must be ≥1.
- `WALK_CYC`, default 240_000_000: pedestrian walk duration; must be ≥1.
- `CNT_W`, default 28: phase counter width; must hold every duration minus 1.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ped_req` in 1: pedestrian request, level or pulse, already synchronised and debounced.
- `ped_ack` out 1: one-cycle pulse when a request is served.
- `a_red`, `a_green`, `a_blue` out 1 each: approach A head, active-low (0 = lit).
- `b_red`, `b_green`, `b_blue` out 1 each: approach B head, active-low.
- `walk` out 1: active-high walk lamp.
- `phase` out 3: current FSM state encoding.

## Operation
- States and `phase` encoding: ALL_RED_A=0, A_GREEN=1, A_CAUTION=2, ALL_RED_B=3, B_GREEN=4, B_CAUTION=5, WALK=6.
- Sequence: ALL_RED_A→A_GREEN→A_CAUTION→ALL_RED_B→B_GREEN→B_CAUTION→(WALK if a request is pending)→ALL_RED_A.
- Durations: ALL_RED_* = RED_CLR_CYC, *_GREEN = GREEN_CYC, *_CAUTION = CAUTION_CYC, WALK = WALK_CYC.
- Head colours, active-low:
  - Red: red=0, green=1, blue=1.
  - Green: 1,0,1.
  - Caution: 1,1,0.
- A head is green only in A_GREEN and caution only in A_CAUTION; otherwise red. The same rule applies to the B head. In WALK both heads are red and `walk`=1; `walk`=0 in every other state.
- Pending flag:
  - Set on any cycle with `ped_req`=1 and state≠WALK.
  - Cleared on entry to WALK.
  - `ped_req` during WALK is ignored.
- WALK decision at the B_CAUTION exit edge uses (pending OR `ped_req`). A request arriving in the final B_CAUTION cycle is therefore served in the same round.
- `ped_ack` pulses high for exactly the first cycle of WALK.
- Illegal `phase` value 7: the next edge forces ALL_RED_A with counter=0 and both heads red.
- Counter: zeroed on every state change. The transition fires on the edge where counter == duration−1, so each state lasts exactly its duration in cycles. The counter never wraps.

## Timing
- All outputs are registered and change on the same edge as `phase`. There is no combinational path from `ped_req` to any output.
- Reset values:
  - `phase`=0 (ALL_RED_A), counter=0, pending=0.
  - `a_red`=`b_red`=0; all green/blue outputs=1.
  - `walk`=0, `ped_ack`=0.
- After `rst` falls, ALL_RED_A lasts RED_CLR_CYC cycles counted from the first non-reset edge.
- `rst` asserted mid-phase, including during WALK, returns to reset values on the next edge and discards any pending request.
- Round period: 2·(RED_CLR_CYC+GREEN_CYC+CAUTION_CYC) without a walk, plus WALK_CYC with one.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - Pending flag, WALK state, `walk` and `ped_ack` are built as described above.
- `TRAFFIC_PED_EN` undefined:
  - `ped_req` is ignored; `walk` and `ped_ack` are tied to 0.
  - WALK is unreachable and B_CAUTION always goes to ALL_RED_A.
  - Encoding 6 is treated as illegal and handled like 7.

## Structure
- Package `traffic_pkg` holds:
  - the phase enum (3-bit, values above);
  - `{red,green,blue}` head constants `HEAD_RED`=3'b011, `HEAD_GREEN`=3'b101, `HEAD_CAUTION`=3'b110;
  - the active-low convention note.
- Sub-module `phase_timer` holds the CNT_W counter:
  - inputs: clear, duration−1;
  - output: `done` when the count matches.
- The FSM, pending flag and output decode stay in `intersection_scheduler`.

## Test plan
All scenarios use RED_CLR_CYC=2, GREEN_CYC=5, CAUTION_CYC=3, WALK_CYC=4, CNT_W=4.
- Reset: hold `rst` 3 cycles → both heads red (0,1,1), `walk`=0, `ped_ack`=0, `phase`=0. `phase`=1 exactly 2 cycles after release.
- No requests: `phase` steps 0,1,2,3,4,5,0 with dwell 2,5,3,2,5,3. Period is 20 cycles. A and B are never non-red simultaneously.
- `ped_req` one-cycle pulse during A_GREEN → after B_CAUTION, `phase`=6 for 4 cycles with `walk`=1 and both heads red. `ped_ack` is high only in the first WALK cycle. Round period is 24.
- `ped_req` high only in the last B_CAUTION cycle → WALK is entered on the next edge. `ped_req` held high throughout WALK → no extra walk in the next round.
- `rst` asserted in WALK cycle 2 → next edge `phase`=0, `walk`=0, pending cleared. The following round has no WALK.
- Build without `TRAFFIC_PED_EN`, `ped_req` held high → `walk`/`ped_ack` stay 0 and the period stays 20.
